// File: rtl/conv_pkg.sv
// Shared types and constants for the single-MAC 3x3 convolution sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    MAC    = 3'd2,
    OUT    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NTAPS = 9;
  localparam int KDIM  = 3;

  // Nine full-width products need four guard bits above the product width.
  function automatic int min_accw(input int xw, input int ww);
    return xw + ww + 4;
  endfunction

endpackage

// File: rtl/mac_accum.sv
// Signed multiply-accumulate: full-width product, sign-extended into a wrapping accumulator.
module mac_accum #(
  parameter int XW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [XW-1:0]   x,
  input  logic signed [WW-1:0]   w,
  output logic signed [ACCW-1:0] sum
);

  logic signed [XW+WW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  acc;

  assign prod     = x * w;
  assign prod_ext = $signed({{(ACCW-XW-WW){prod[XW+WW-1]}}, prod});
  // sum is the value acc takes on an enabled edge; the owner can capture it on the last tap.
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv3x3_mac_sequencer.sv
// Valid-mode 3x3 convolution controller: loads 9 weights, then walks windows row-major
// through one MAC, issuing 9 pixel reads per window and emitting one result per window.
module conv3x3_mac_sequencer
  import conv_pkg::*;
#(
  parameter int XW    = 8,
  parameter int WW    = 8,
  parameter int ACCW  = 20,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_w_valid,
  input  logic signed [WW-1:0]   i_w,
  output logic                   o_w_ready,
  output logic                   o_pix_rd,
  output logic [AW-1:0]          o_pix_addr,
  input  logic signed [XW-1:0]   i_pix_data,
  output logic signed [ACCW-1:0] o_result,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam logic [3:0] LAST_W   = 4'(NTAPS - 1);
  localparam logic [3:0] LAST_TAP = 4'(NTAPS);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 3);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 3);

  if (ACCW < min_accw(XW, WW)) begin : g_accw_check
    $error("ACCW narrower than XW+WW+4");
  end

  state_t state, state_nxt;

  logic [3:0]           k;
  logic [3:0]           t;
  logic [3:0]           tap_d;
  logic [RW-1:0]        r;
  logic [CW-1:0]        c;
  logic signed [WW-1:0] w [NTAPS];
  logic signed [WW-1:0] w_sel;
  logic signed [ACCW-1:0] mac_sum;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 last_w;
  logic                 last_win;
  logic                 out_hs;
  int                   row;
  int                   col;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Weights: i_w_valid/o_w_ready. Results: o_valid/i_ready; o_result holds until the transfer.
  assign last_w   = (state == LOAD_W) && i_w_valid && (k == LAST_W);
  assign last_win = (r == LAST_R) && (c == LAST_C);
  assign out_hs   = (state == OUT) && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_w_ready = 1'b0;
    o_pix_rd  = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        o_w_ready = 1'b1;
        if (last_w) state_nxt = MAC;
      end
      MAC: begin
        o_pix_rd = (t != LAST_TAP);
        if (t == LAST_TAP) state_nxt = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (out_hs) state_nxt = last_win ? DONE : MAC;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Tap t maps to window offset (t/3, t%3); the address is driven only while reading.
  always_comb begin
    row        = int'(r) + int'(t) / KDIM;
    col        = int'(c) + int'(t) % KDIM;
    o_pix_addr = '0;
    if (o_pix_rd) o_pix_addr = AW'(row * IMG_W + col);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      k        <= '0;
      t        <= '0;
      tap_d    <= '0;
      r        <= '0;
      c        <= '0;
      o_result <= '0;
      for (int i = 0; i < NTAPS; i++) w[i] <= '0;
    end else begin
      tap_d <= t;
      case (state)
        IDLE: begin
          if (i_start) begin
            k <= '0;
            r <= '0;
            c <= '0;
          end
        end
        LOAD_W: begin
          if (i_w_valid) begin
            w[k] <= i_w;
            k    <= k + 4'd1;
          end
        end
        MAC: begin
          if (t == LAST_TAP) begin
            t        <= '0;
            o_result <= mac_sum;
          end else begin
            t <= t + 4'd1;
          end
        end
        OUT: begin
          if (i_ready) begin
            if (c == LAST_C) begin
              c <= '0;
              r <= r + RW'(1);
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lags the strobe by one cycle, so tap t consumes the pixel read at t-1.
  assign mac_clr = (state == MAC) && (t == 4'd0);
  assign mac_en  = (state == MAC) && (t != 4'd0);
  assign w_sel   = (tap_d < LAST_TAP) ? w[tap_d] : '0;

  mac_accum #(
    .XW  (XW),
    .WW  (WW),
    .ACCW(ACCW)
  ) u_mac (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .x    (i_pix_data),
    .w    (w_sel),
    .sum  (mac_sum)
  );

endmodule

// File: tb/tb_conv3x3_mac_sequencer.sv
// Directed bench: a 4x4 instance checked for values, ordering and timing, and an 8x8 instance
// used for the mid-frame reset scenario. Both share control inputs.
module tb_conv3x3_mac_sequencer;

  localparam int ACCW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic              w_valid;
  logic signed [7:0] w_in;
  logic              ready;

  logic              w_ready4, pix_rd4, valid4, busy4, done4;
  logic [3:0]        addr4;
  logic signed [7:0] pd4 = '0;
  logic [ACCW-1:0]   res4;

  logic              w_ready8, pix_rd8, valid8, busy8, done8;
  logic [5:0]        addr8;
  logic signed [7:0] pd8 = '0;
  logic [ACCW-1:0]   res8;

  logic signed [7:0] pix4 [16];
  logic signed [7:0] pix8 [64];
  logic signed [7:0] wts  [9];

  logic [ACCW-1:0]   exp_q[$];
  logic [ACCW-1:0]   exp_val;
  int                n_checks  = 0;
  int                n_pass    = 0;
  int                hs8_cnt   = 0;
  int                excl_viol = 0;

  conv3x3_mac_sequencer #(
    .XW(8), .WW(8), .ACCW(ACCW), .IMG_W(4), .IMG_H(4), .AW(4)
  ) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_w_valid(w_valid), .i_w(w_in),
    .o_w_ready(w_ready4), .o_pix_rd(pix_rd4), .o_pix_addr(addr4), .i_pix_data(pd4),
    .o_result(res4), .o_valid(valid4), .i_ready(ready), .o_busy(busy4), .o_done(done4)
  );

  conv3x3_mac_sequencer #(
    .XW(8), .WW(8), .ACCW(ACCW), .IMG_W(8), .IMG_H(8), .AW(6)
  ) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_w_valid(w_valid), .i_w(w_in),
    .o_w_ready(w_ready8), .o_pix_rd(pix_rd8), .o_pix_addr(addr8), .i_pix_data(pd8),
    .o_result(res8), .o_valid(valid8), .i_ready(ready), .o_busy(busy8), .o_done(done8)
  );

  // Single-port pixel memories with one cycle of read latency.
  always @(posedge clk) begin
    if (pix_rd4) pd4 <= pix4[addr4];
    if (pix_rd8) pd8 <= pix8[addr8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard for 4x4 results plus handshake exclusivity on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int'(w_ready4) + int'(pix_rd4) + int'(valid4)) > 1) excl_viol = excl_viol + 1;
      if ((int'(w_ready8) + int'(pix_rd8) + int'(valid8)) > 1) excl_viol = excl_viol + 1;
      if (valid4 && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result4", 32'd1, 32'd0);
        end else begin
          exp_val = exp_q.pop_front();
          check("result4", 32'(res4), 32'(exp_val));
        end
      end
      if (valid8 && ready) hs8_cnt = hs8_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_weights(input bit gaps);
    for (int k = 0; k < 9; k++) begin
      if (gaps) begin
        w_valid = 1'b0;
        repeat ($urandom_range(3, 0)) tick();
      end
      w_valid = 1'b1;
      w_in    = wts[k];
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy4 || busy8) && n < 1000) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy4 || busy8), 32'd0);
  endtask

  task automatic wait_valid4();
    int n = 0;
    @(negedge clk);
    while (!valid4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("valid4_timeout", 32'(valid4), 32'd1);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_q.push_back(ACCW'(a));
    exp_q.push_back(ACCW'(b));
    exp_q.push_back(ACCW'(c));
    exp_q.push_back(ACCW'(d));
  endtask

  initial begin
    int  nhs;
    bit  prev_hs;
    bit  seen;
    int  base;
    int  n;

    rst_n   = 1'b0;
    start   = 1'b0;
    w_valid = 1'b0;
    w_in    = '0;
    ready   = 1'b1;
    for (int a = 0; a < 16; a++) pix4[a] = 8'(a);
    for (int a = 0; a < 64; a++) pix8[a] = 8'(a);
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_valid4", 32'(valid4), 32'd0);
    check("rst_pix_rd4", 32'(pix_rd4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_w_ready4", 32'(w_ready4), 32'd0);
    check("rst_result4", 32'(res4), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Weight valid in IDLE is ignored
    w_valid = 1'b1;
    w_in    = 8'sd77;
    tick();
    w_valid = 1'b0;
    @(negedge clk);
    check("idle_w_ready4", 32'(w_ready4), 32'd0);
    check("idle_busy4", 32'(busy4), 32'd0);
    tick();

    // Frame A: weights 1, pixel[a]=a, timing and ordering
    for (int k = 0; k < 9; k++) wts[k] = 8'sd1;
    push4(45, 54, 81, 90);
    start_frame();
    load_weights(1'b0);
    @(negedge clk);
    check("first_rd4", 32'(pix_rd4), 32'd1);
    check("first_addr4", 32'(addr4), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("valid_early4", 32'(valid4), 32'd0);
    @(negedge clk);
    check("valid_t11_4", 32'(valid4), 32'd1);
    check("busy_mid4", 32'(busy4), 32'd1);
    nhs = 0;
    prev_hs = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done4) begin
        seen = 1'b1;
      end else begin
        prev_hs = valid4 && ready;
        if (prev_hs) nhs++;
        @(negedge clk);
      end
    end
    check("done_seen4", 32'(seen), 32'd1);
    check("done_after_hs4", 32'(prev_hs), 32'd1);
    check("hs_count4", 32'(nhs), 32'd4);
    @(negedge clk);
    check("done_pulse4", 32'(done4), 32'd0);
    check("idle_after_done4", 32'(busy4), 32'd0);
    wait_idle();

    // Frame B: signed extremes with backpressure on the first result
    for (int a = 0; a < 16; a++) pix4[a] = 8'sd127;
    for (int a = 0; a < 64; a++) pix8[a] = 8'sd127;
    for (int k = 0; k < 9; k++) wts[k] = -8'sd128;
    push4(-146304, -146304, -146304, -146304);
    ready = 1'b0;
    start_frame();
    load_weights(1'b0);
    wait_valid4();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid4", 32'(valid4), 32'd1);
      check("bp_result4", 32'(res4), 32'h000DC480);
      check("bp_no_rd4", 32'(pix_rd4), 32'd0);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_resume_rd4", 32'(pix_rd4), 32'd1);
    check("bp_resume_addr4", 32'(addr4), 32'd1);
    wait_idle();

    // Frame C: weights 1..9 with random gaps, constant pixel 2
    for (int a = 0; a < 16; a++) pix4[a] = 8'sd2;
    for (int a = 0; a < 64; a++) pix8[a] = 8'sd2;
    for (int k = 0; k < 9; k++) wts[k] = 8'(k + 1);
    push4(90, 90, 90, 90);
    start_frame();
    load_weights(1'b1);
    wait_idle();

    // Frame D: reset during MAC of 8x8 window (1,2), then restart at (0,0)
    for (int a = 0; a < 16; a++) pix4[a] = 8'(a);
    for (int a = 0; a < 64; a++) pix8[a] = 8'(a);
    for (int k = 0; k < 9; k++) wts[k] = 8'sd1;
    push4(45, 54, 81, 90);
    base = hs8_cnt;
    start_frame();
    load_weights(1'b0);
    n = 0;
    while (hs8_cnt < base + 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("hs8_reach8", 32'(hs8_cnt - base), 32'd8);
    tick();
    tick();
    @(negedge clk);
    check("mid_mac_rd8", 32'(pix_rd8), 32'd1);
    check("q_empty_before_rst", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid8", 32'(valid8), 32'd0);
    check("rst_mid_busy8", 32'(busy8), 32'd0);
    check("rst_mid_pix_rd8", 32'(pix_rd8), 32'd0);
    check("rst_mid_done8", 32'(done8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    push4(45, 54, 81, 90);
    start_frame();
    load_weights(1'b0);
    @(negedge clk);
    check("restart_rd8", 32'(pix_rd8), 32'd1);
    check("restart_addr8", 32'(addr8), 32'd0);
    n = 0;
    while (!valid8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("restart_valid8", 32'(valid8), 32'd1);
    check("restart_result8", 32'(res8), 32'd81);
    wait_idle();

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    check("exclusive_handshakes", 32'(excl_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
